// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the sequential shift-add multiplier.
//   mul_state_t : FSM state encoding (IDLE / RUN / FIX)
//   MUL_CNT_W   : width of the bit counter used during RUN
//   MUL_WIDTH   : the only operand width the datapath supports
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_FIX  = 2'd2
   } mul_state_t;

   localparam int MUL_CNT_W = 5;
   localparam int MUL_WIDTH = 32;

endpackage

// File: rtl/seq_multiplier_adder_32bit.sv
// -----------------------------------------------------------------------------
// adder_32bit
// Plain 32-bit ripple/behavioural adder used for the accumulate step.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low 32 bits
//   cout : carry out of bit 31
// -----------------------------------------------------------------------------
module adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle shift-add multiplier for MULT / MULTU. One addition per cycle
// through adder_32bit; the 64-bit product lands in {hi,lo}.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (abandons any operation)
//   start     : request, sampled only while busy=0
//   is_signed : 1 = MULT (two's complement), 0 = MULTU; sampled with start
//   op_a      : multiplicand, sampled with start
//   op_b      : multiplier, sampled with start
//   busy      : high in RUN and FIX
//   done      : one-cycle pulse; hi/lo valid in that cycle
//   hi, lo    : product[63:32] / product[31:0], held until the next FIX
//
// Handshake: a request is accepted on any edge where start=1 and busy=0
// (including the done cycle). While busy=1, start and operands are ignored.
// done pulses for exactly one cycle, the first IDLE cycle after FIX.
// -----------------------------------------------------------------------------
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH     = MUL_WIDTH,  // only 32 works with adder_32bit
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mul_state_t             state;
   logic [MUL_CNT_W-1:0]   count;
   logic                   neg;
   logic [WIDTH-1:0]       mcand;
   logic [WIDTH-1:0]       acc_hi;
   logic [WIDTH-1:0]       acc_lo;

   logic                   signed_op;
   logic [WIDTH-1:0]       a_mag;
   logic [WIDTH-1:0]       b_mag;
   logic [WIDTH-1:0]       add_b;
   logic [WIDTH-1:0]       sum;
   logic                   cout;
   logic [2*WIDTH-1:0]     acc_full;

   assign signed_op = SIGNED_EN & is_signed;

   // Magnitudes: -2^31 negates to itself, which read as unsigned is the
   // correct magnitude 0x8000_0000.
   assign a_mag = (signed_op && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
   assign b_mag = (signed_op && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

   assign add_b    = acc_lo[0] ? mcand : '0;
   assign acc_full = {acc_hi, acc_lo};

   adder_32bit u_adder (
      .a    (acc_hi),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   assign busy = (state == MUL_RUN) || (state == MUL_FIX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= MUL_IDLE;
         count  <= '0;
         neg    <= 1'b0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MUL_IDLE: begin
               if (start) begin
                  neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  mcand  <= a_mag;
                  acc_hi <= '0;
                  acc_lo <= b_mag;
                  count  <= '0;
                  state  <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               // Carry out becomes the new top bit as the pair shifts right.
               {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]};
               count <= count + MUL_CNT_W'(1);
               if (count == MUL_CNT_W'(WIDTH-1)) begin
                  state <= MUL_FIX;
               end
            end
            MUL_FIX: begin
               {hi, lo} <= neg ? (~acc_full + (2*WIDTH)'(1)) : acc_full;
               done     <= 1'b1;
               state    <= MUL_IDLE;
            end
            default: begin
               state <= MUL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier: directed cases plus randomized
// operands, compared against a plain-arithmetic 64-bit product model.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int errors;

   logic [63:0] exp_q[$];

   seq_multiplier #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0] ua;
      logic [63:0] ub;
      if (s) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         return 64'(sa * sb);
      end else begin
         ua = {32'b0, a};
         ub = {32'b0, b};
         return ua * ub;
      end
   endfunction

   // ---------------- scoreboard compare ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- drivers ----------------
   // Present a request for one edge; returns in the first cycle after acceptance.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      start     = 1'b1;
      op_a      = a;
      op_b      = b;
      is_signed = s;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Counts cycles (first cycle after acceptance = 1) until done is seen.
   task automatic wait_done(input logic [63:0] held, output int lat, output int busy_cnt,
                            output int unstable);
      lat      = 1;
      busy_cnt = 0;
      unstable = 0;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1) busy_cnt++;
         if ({hi, lo} !== held) unstable++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) n++;
      end
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
      logic [63:0] held;
      int lat, bc, unst;
      held = {hi, lo};
      exp_q.push_back(ref_mul(a, b, s));
      start_op(a, b, s);
      wait_done(held, lat, bc, unst);
      chk({tag, " latency"}, 64'(lat), 64'd34);
      chk({tag, " busy_cycles"}, 64'(bc), 64'd33);
      chk({tag, " hold_while_busy"}, 64'(unst), 64'd0);
      chk({tag, " product"}, {hi, lo}, exp_q.pop_front());
      @(negedge clk);
      chk({tag, " done_one_pulse"}, {63'd0, done}, 64'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [63:0] held;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int lat, bc, unst, nd;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      op_a      = '0;
      op_b      = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset hilo", {hi, lo}, 64'd0);

      // 1-3: directed products
      run_check("multu_3x5", 32'd3, 32'd5, 1'b0);
      chk("multu_3x5 lo_const", {hi, lo}, 64'h0000_0000_0000_000F);
      run_check("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_check("mult_m7x6", 32'hFFFF_FFF9, 32'd6, 1'b1);
      chk("mult_m7x6 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
      run_check("mult_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1);
      chk("mult_min_sq const", {hi, lo}, 64'h4000_0000_0000_0000);
      run_check("mult_zero_neg", 32'd0, 32'hFFFF_FFFF, 1'b1);
      run_check("multu_min", 32'h8000_0000, 32'd2, 1'b0);

      // 4: re-pulsed start during RUN is ignored
      held = {hi, lo};
      r1   = ref_mul(32'd100, 32'd200, 1'b0);
      start_op(32'd100, 32'd200, 1'b0);
      repeat (5) @(negedge clk);
      start_op(32'd7, 32'd9, 1'b0);
      wait_done(held, lat, bc, unst);
      chk("repulse latency", 64'(lat + 7), 64'd34);
      chk("repulse product", {hi, lo}, r1);
      count_dones(40, nd);
      chk("repulse single_done", 64'(nd), 64'd0);

      // 5: reset in the middle of RUN
      start_op(32'd123, 32'd456, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", {63'd0, busy}, 64'd0);
      chk("midrst done", {63'd0, done}, 64'd0);
      chk("midrst hilo", {hi, lo}, 64'd0);
      count_dones(40, nd);
      chk("midrst no_done", 64'(nd), 64'd0);
      run_check("after_rst_2x2", 32'd2, 32'd2, 1'b0);
      chk("after_rst_2x2 const", {hi, lo}, 64'd4);

      // 6: back-to-back with start held through the done cycle
      held = {hi, lo};
      r1   = ref_mul(32'd1000, 32'd3, 1'b0);
      r2   = ref_mul(32'd5, 32'hFFFF_FFFD, 1'b1);
      @(negedge clk);
      start     = 1'b1;
      op_a      = 32'd1000;
      op_b      = 32'd3;
      is_signed = 1'b0;
      @(negedge clk);
      op_a = 32'h1234_5678;   // must be ignored while busy
      op_b = 32'h0BAD_F00D;
      wait_done(held, lat, bc, unst);
      chk("b2b first latency", 64'(lat), 64'd34);
      chk("b2b first product", {hi, lo}, r1);
      op_a      = 32'd5;
      op_b      = 32'hFFFF_FFFD;
      is_signed = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(r1, lat, bc, unst);
      chk("b2b second latency", 64'(lat), 64'd34);
      chk("b2b hold_first", 64'(unst), 64'd0);
      chk("b2b second product", {hi, lo}, r2);

      // randomized operands, with occasional corner values
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: ra = 32'd0;
            1: rb = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            3: rb = 32'd1;
            default: ;
         endcase
         run_check($sformatf("rand%0d", i), ra, rb, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
